// File: rtl/decoded_inst_queue.sv
// Purpose: circular FIFO of decoded instructions (control word, PC, raw word) between decode and issue.
// Latency: 1 cycle enqueue-to-head; 0 cycles with BYPASS=1 while empty (input forwarded straight to head).
// Backpressure: in_ready drops when full or flushing; no push-through at full; out_valid held low during flush.
//
// Ports:
//   clk, rst (sync, active-high), flush (sync discard of all entries)
//   in_valid/in_ready + in_cw/in_pc/in_instr   : producer side
//   out_valid/out_ready + out_cw/out_pc/out_instr : consumer side (head entry)
//   count/full/empty : occupancy decodes of the registered count
module decoded_inst_queue #(
    parameter int DEPTH    = 4,
    parameter int CW_WIDTH = 32,
    parameter int XLEN     = 32,
    parameter int BYPASS   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CW_WIDTH-1:0]        in_cw,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CW_WIDTH-1:0]        out_cw,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [CW_WIDTH-1:0] cw;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     instr;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] cnt_q;

    logic   push;
    logic   pop;
    logic   bypass_active;
    logic   wr_en;
    logic   rd_adv;
    entry_t in_entry;
    entry_t head_entry;

    // Occupancy flags come from the registered count only; flush does not
    // alter them until the following cycle.
    assign count = cnt_q;
    assign full  = (cnt_q == CNTW'(DEPTH));
    assign empty = (cnt_q == '0);

    assign bypass_active = (BYPASS != 0) && empty;

    assign in_ready = !full && !flush;

    always_comb begin
        out_valid = 1'b0;
        if (bypass_active) begin
            out_valid = in_valid && !flush;
        end else begin
            out_valid = !empty && !flush;
        end
    end

    assign in_entry = '{cw: in_cw, pc: in_pc, instr: in_instr};
    assign head_entry = bypass_active ? in_entry : mem[rd_ptr];

    assign out_cw    = head_entry.cw;
    assign out_pc    = head_entry.pc;
    assign out_instr = head_entry.instr;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // A forwarded entry that is consumed in the same cycle never touches
    // storage; otherwise a forwarded-but-not-taken entry is written normally.
    assign wr_en  = push && !(bypass_active && pop);
    assign rd_adv = pop && !bypass_active;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_adv})
                2'b10:   cnt_q <= cnt_q + CNTW'(1);
                2'b01:   cnt_q <= cnt_q - CNTW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Payload storage carries no reset; stale contents are never observed
    // because out_valid gates them.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= in_entry;
        end
    end

endmodule

// File: tb/tb_decoded_inst_queue.sv
module tb_decoded_inst_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] cw;
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_cw, in_pc, in_instr;

    logic        in_ready0, out_valid0, full0, empty0;
    logic [31:0] out_cw0, out_pc0, out_instr0;
    logic [2:0]  count0;
    logic        in_ready1, out_valid1, full1, empty1;
    logic [31:0] out_cw1, out_pc1, out_instr1;
    logic [2:0]  count1;

    int n_vec = 0;
    int n_err = 0;

    // Reference queues: q0 models the plain queue, q1 the bypass-enabled one.
    ent_t q0[$];
    ent_t q1[$];

    always #5 clk = ~clk;

    decoded_inst_queue #(.DEPTH(DEPTH), .CW_WIDTH(32), .XLEN(32), .BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_cw(in_cw), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_cw(out_cw0), .out_pc(out_pc0), .out_instr(out_instr0),
        .count(count0), .full(full0), .empty(empty0)
    );

    decoded_inst_queue #(.DEPTH(DEPTH), .CW_WIDTH(32), .XLEN(32), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_cw(in_cw), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_cw(out_cw1), .out_pc(out_pc1), .out_instr(out_instr1),
        .count(count1), .full(full1), .empty(empty1)
    );

    // Expected head-valid for a queue holding sz entries under current inputs.
    function automatic bit exp_ovalid(int sz, bit byp);
        if (flush) return 1'b0;
        if (sz > 0) return 1'b1;
        return byp && in_valid;
    endfunction

    function automatic bit exp_iready(int sz);
        return (sz < DEPTH) && !flush;
    endfunction

    // Drive one cycle of inputs; payload other than PC is random.
    task automatic drive(bit v, logic [31:0] pc, bit ordy, bit fl, bit rs);
        in_valid  = v;
        in_pc     = pc;
        in_cw     = $urandom;
        in_instr  = $urandom;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #1;
    endtask

    // Advance one clock and apply the same transfer rules to the reference queues.
    task automatic tick();
        ent_t cur;
        int   sz;
        bit   ov, ir, pop, push;
        @(posedge clk);
        cur = '{cw: in_cw, pc: in_pc, instr: in_instr};
        // plain queue
        sz = q0.size(); ov = exp_ovalid(sz, 1'b0); ir = exp_iready(sz);
        if (rst || flush) q0.delete();
        else begin
            pop = ov && out_ready; push = in_valid && ir;
            if (pop) void'(q0.pop_front());
            if (push) q0.push_back(cur);
        end
        // bypass queue: an empty queue hands the input straight to a ready consumer
        sz = q1.size(); ov = exp_ovalid(sz, 1'b1); ir = exp_iready(sz);
        if (rst || flush) q1.delete();
        else begin
            pop = ov && out_ready; push = in_valid && ir;
            if (!(pop && sz == 0)) begin
                if (pop) void'(q1.pop_front());
                if (push) q1.push_back(cur);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive(0, 32'h0, 0, 0, 1);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 32'h0, 0, 0, 0);
        n_vec++;
        if ({count0, empty0, full0, in_ready0, out_valid0} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL reset_dut0 got cnt=%0d e=%b f=%b ir=%b ov=%b exp cnt=0 e=1 f=0 ir=1 ov=0",
                     count0, empty0, full0, in_ready0, out_valid0);
            n_err++;
        end
        n_vec++;
        if ({count1, empty1, in_ready1, out_valid1} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
            $display("FAIL reset_dut1 got cnt=%0d e=%b ir=%b ov=%b exp cnt=0 e=1 ir=1 ov=0",
                     count1, empty1, in_ready1, out_valid1);
            n_err++;
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h100 + 32'(4*i), 0, 0, 0);
            n_vec++;
            if (in_ready0 !== 1'b1) begin
                $display("FAIL fill_in_ready[%0d] got %b exp 1", i, in_ready0); n_err++;
            end
            tick();
        end
        drive(1, 32'h110, 1, 0, 0);
        n_vec++;
        if ({full0, in_ready0, count0} !== {1'b1, 1'b0, 3'd4}) begin
            $display("FAIL full_state got f=%b ir=%b cnt=%0d exp f=1 ir=0 cnt=4", full0, in_ready0, count0);
            n_err++;
        end
        tick(); // pop with push held off at full: the 0x110 push must not land
        for (int i = 1; i < 4; i++) begin
            drive(0, 32'h0, 1, 0, 0);
            n_vec++;
            if (out_valid0 !== 1'b1 || out_pc0 !== 32'h100 + 32'(4*i)) begin
                $display("FAIL drain_pc[%0d] got ov=%b pc=%h exp ov=1 pc=%h", i, out_valid0, out_pc0, 32'h100 + 32'(4*i));
                n_err++;
            end
            n_vec++;
            if (out_pc1 !== 32'h100 + 32'(4*i)) begin
                $display("FAIL drain_pc_byp[%0d] got %h exp %h", i, out_pc1, 32'h100 + 32'(4*i)); n_err++;
            end
            tick();
        end
        drive(0, 32'h0, 1, 0, 0);
        n_vec++;
        if ({empty0, out_valid0, count0} !== {1'b1, 1'b0, 3'd0}) begin
            $display("FAIL drained got e=%b ov=%b cnt=%0d exp e=1 ov=0 cnt=0", empty0, out_valid0, count0);
            n_err++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h300 + 32'(4*i), 0, 0, 0);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            drive(1, 32'h30C + 32'(4*k), 1, 0, 0);
            n_vec++;
            if (out_pc0 !== 32'h300 + 32'(4*k) || count0 !== 3'd3) begin
                $display("FAIL wrap[%0d] got pc=%h cnt=%0d exp pc=%h cnt=3", k, out_pc0, count0, 32'h300 + 32'(4*k));
                n_err++;
            end
            tick();
        end
        drive(0, 32'h0, 0, 0, 0);
        n_vec++;
        if (count0 !== 3'd3 || out_pc0 !== 32'h320) begin
            $display("FAIL wrap_end got cnt=%0d pc=%h exp cnt=3 pc=00000320", count0, out_pc0); n_err++;
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h400 + 32'(4*i), 0, 0, 0);
            tick();
        end
        drive(1, 32'h408, 1, 1, 0);
        n_vec++;
        if ({out_valid0, in_ready0, count0, out_valid1} !== {1'b0, 1'b0, 3'd2, 1'b0}) begin
            $display("FAIL flush_cycle got ov=%b ir=%b cnt=%0d ov1=%b exp ov=0 ir=0 cnt=2 ov1=0",
                     out_valid0, in_ready0, count0, out_valid1);
            n_err++;
        end
        tick();
        drive(0, 32'h0, 0, 0, 0);
        n_vec++;
        if ({count0, empty0, out_valid0, count1} !== {3'd0, 1'b1, 1'b0, 3'd0}) begin
            $display("FAIL flush_after got cnt=%0d e=%b ov=%b cnt1=%0d exp cnt=0 e=1 ov=0 cnt1=0",
                     count0, empty0, out_valid0, count1);
            n_err++;
        end
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1, 32'h200, 1, 0, 0);
        n_vec++;
        if ({out_valid1, in_ready1, out_valid0} !== 3'b110 || out_pc1 !== 32'h200 || out_instr1 !== in_instr) begin
            $display("FAIL bypass_fwd got ov1=%b ir1=%b ov0=%b pc1=%h exp ov1=1 ir1=1 ov0=0 pc1=00000200",
                     out_valid1, in_ready1, out_valid0, out_pc1);
            n_err++;
        end
        tick();
        drive(0, 32'h0, 0, 0, 0);
        n_vec++;
        if (count1 !== 3'd0 || count0 !== 3'd1) begin
            $display("FAIL bypass_count got cnt1=%0d cnt0=%0d exp cnt1=0 cnt0=1", count1, count0); n_err++;
        end
        do_reset();
        drive(1, 32'h204, 0, 0, 0);
        n_vec++;
        if (out_valid1 !== 1'b1 || out_pc1 !== 32'h204) begin
            $display("FAIL bypass_hold got ov=%b pc=%h exp ov=1 pc=00000204", out_valid1, out_pc1); n_err++;
        end
        tick();
        drive(0, 32'h0, 0, 0, 0);
        n_vec++;
        if (count1 !== 3'd1 || out_valid1 !== 1'b1 || out_pc1 !== 32'h204) begin
            $display("FAIL bypass_stored got cnt=%0d ov=%b pc=%h exp cnt=1 ov=1 pc=00000204", count1, out_valid1, out_pc1);
            n_err++;
        end
    endtask

    task automatic test_rst_flush();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h500 + 32'(4*i), 0, 0, 0);
            tick();
        end
        drive(0, 32'h0, 0, 1, 1);
        tick();
        drive(0, 32'h0, 0, 0, 0);
        n_vec++;
        if ({empty0, empty1, full0, count0, in_ready0} !== {1'b1, 1'b1, 1'b0, 3'd0, 1'b1}) begin
            $display("FAIL rst_flush got e0=%b e1=%b f0=%b cnt0=%0d ir0=%b exp e0=1 e1=1 f0=0 cnt0=0 ir0=1",
                     empty0, empty1, full0, count0, in_ready0);
            n_err++;
        end
    endtask

    task automatic test_random();
        int  rdy_pct;
        int  sz;
        bit  ov;
        ent_t h;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (c % 200 == 0) rdy_pct = (c % 400 == 0) ? 20 : 80;
            drive($urandom_range(0, 99) < 70, $urandom,
                  $urandom_range(0, 99) < rdy_pct,
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 299) == 0);
            // plain queue
            sz = q0.size(); ov = exp_ovalid(sz, 1'b0);
            n_vec++;
            if ({in_ready0, out_valid0, full0, empty0, count0} !==
                {exp_iready(sz), ov, sz == DEPTH, sz == 0, 3'(sz)}) begin
                $display("FAIL rnd_ctl0 c=%0d got ir=%b ov=%b f=%b e=%b cnt=%0d exp ir=%b ov=%b cnt=%0d",
                         c, in_ready0, out_valid0, full0, empty0, count0, exp_iready(sz), ov, sz);
                n_err++;
            end
            if (ov) begin
                h = q0[0];
                n_vec++;
                if ({out_cw0, out_pc0, out_instr0} !== {h.cw, h.pc, h.instr}) begin
                    $display("FAIL rnd_dat0 c=%0d got pc=%h cw=%h exp pc=%h cw=%h", c, out_pc0, out_cw0, h.pc, h.cw);
                    n_err++;
                end
            end
            // bypass queue
            sz = q1.size(); ov = exp_ovalid(sz, 1'b1);
            n_vec++;
            if ({in_ready1, out_valid1, full1, empty1, count1} !==
                {exp_iready(sz), ov, sz == DEPTH, sz == 0, 3'(sz)}) begin
                $display("FAIL rnd_ctl1 c=%0d got ir=%b ov=%b f=%b e=%b cnt=%0d exp ir=%b ov=%b cnt=%0d",
                         c, in_ready1, out_valid1, full1, empty1, count1, exp_iready(sz), ov, sz);
                n_err++;
            end
            if (ov) begin
                h = (sz > 0) ? q1[0] : '{cw: in_cw, pc: in_pc, instr: in_instr};
                n_vec++;
                if ({out_cw1, out_pc1, out_instr1} !== {h.cw, h.pc, h.instr}) begin
                    $display("FAIL rnd_dat1 c=%0d got pc=%h cw=%h exp pc=%h cw=%h", c, out_pc1, out_cw1, h.pc, h.cw);
                    n_err++;
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_cw = '0; in_pc = '0; in_instr = '0;
        #1;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_flush();
        test_bypass();
        test_rst_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
